// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC mux, imem request handshake and IF/ID latch.
// Optional halt support is enabled by defining FETCH_HALT_EN.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        stall_PC,
  input  logic        stall_IFID,
  input  logic        flush_IFID,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] branch_tgt,
  input  logic [31:0] jump_tgt,
  input  logic [31:0] jr_tgt,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        halt
);

`ifdef FETCH_HALT_EN
  typedef enum logic [1:0] {FETCH = 2'd0, KILL = 2'd1, HALTED = 2'd2} state_t;
`else
  typedef enum logic [1:0] {FETCH = 2'd0, KILL = 2'd1} state_t;
`endif

  state_t      state, next_state;
  logic [31:0] pc, next_pc;
  logic [31:0] redir_pc, next_redir;
  logic [31:0] pc4;
  logic [31:0] target;
  logic        redirect;
  logic        accept;

  assign pc4      = pc + 32'd4;
  assign redirect = (PCSrc != 2'd0);
  assign iaddr    = pc;

  always_comb begin
    target = pc4;
    case (PCSrc)
      2'd1:    target = branch_tgt;
      2'd2:    target = jump_tgt;
      2'd3:    target = jr_tgt;
      default: target = pc4;
    endcase
  end

  // A redirect with the request still open parks the target until the stale word returns.
  always_comb begin
    next_state = state;
    next_pc    = pc;
    next_redir = redir_pc;
    accept     = 1'b0;
    case (state)
      FETCH: begin
        if (redirect) begin
          if (ihit) begin
            next_pc = target;
          end else begin
            next_redir = target;
            next_state = KILL;
          end
        end else if (ihit && !stall_PC) begin
          accept  = 1'b1;
          next_pc = pc4;
`ifdef FETCH_HALT_EN
          if (iload == 32'hFFFF_FFFF) next_state = HALTED;
`endif
        end
      end
      KILL: begin
        if (redirect) next_redir = target;
        if (ihit) begin
          next_pc    = redirect ? target : redir_pc;
          next_state = FETCH;
        end
      end
`ifdef FETCH_HALT_EN
      HALTED: begin
        if (redirect) begin
          next_pc    = target;
          next_state = FETCH;
        end
      end
`endif
      default: next_state = FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state    <= FETCH;
      pc       <= PC_INIT;
      redir_pc <= PC_INIT;
    end else begin
      state    <= next_state;
      pc       <= next_pc;
      redir_pc <= next_redir;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      ifid_instr <= 32'd0;
      ifid_pc4   <= 32'd0;
      ifid_valid <= 1'b0;
    end else if (flush_IFID) begin
      ifid_instr <= 32'd0;
      ifid_valid <= 1'b0;
    end else if (stall_IFID) begin
      ifid_instr <= ifid_instr;
    end else if (accept) begin
      ifid_instr <= iload;
      ifid_pc4   <= pc4;
      ifid_valid <= 1'b1;
    end else begin
      ifid_instr <= 32'd0;
      ifid_valid <= 1'b0;
    end
  end

`ifdef FETCH_HALT_EN
  assign iREN = nRST && (state != HALTED);
  assign halt = (state == HALTED);
`else
  assign iREN = nRST;
  assign halt = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then randomized traffic
// against a rule-level reference model.
module tb_fetch_stage;

  localparam logic [31:0] PC_INIT = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        nRST, ihit, stall_PC, stall_IFID, flush_IFID;
  logic [31:0] iload, branch_tgt, jump_tgt, jr_tgt;
  logic [1:0]  PCSrc;
  logic        iREN, ifid_valid, halt;
  logic [31:0] iaddr, ifid_instr, ifid_pc4;

  int tests = 0;
  int failures = 0;

  // reference model
  logic [31:0] m_pc, m_redir, m_instr, m_pc4;
  logic        m_killing, m_halted, m_valid, m_known;

  always #5 CLK = ~CLK;

  fetch_stage #(.PC_INIT(PC_INIT)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .iload(iload), .iREN(iREN), .iaddr(iaddr),
    .stall_PC(stall_PC), .stall_IFID(stall_IFID), .flush_IFID(flush_IFID), .PCSrc(PCSrc),
    .branch_tgt(branch_tgt), .jump_tgt(jump_tgt), .jr_tgt(jr_tgt),
    .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid), .halt(halt)
  );

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [31:0] tgt;
    logic        accepted;
    logic [31:0] word;
    if (!nRST) begin
      m_pc = PC_INIT; m_killing = 0; m_halted = 0;
      m_instr = 0; m_pc4 = 0; m_valid = 0; m_known = 1;
      return;
    end
    case (PCSrc)
      2'd1: tgt = branch_tgt;
      2'd2: tgt = jump_tgt;
      2'd3: tgt = jr_tgt;
      default: tgt = m_pc + 32'd4;
    endcase
    accepted = 0;
    word = iload;
    if (m_halted) begin
      if (PCSrc != 0) begin m_pc = tgt; m_halted = 0; end
    end else if (m_killing) begin
      if (PCSrc != 0) m_redir = tgt;
      if (ihit) begin m_pc = m_redir; m_killing = 0; end
    end else if (PCSrc != 0) begin
      if (ihit) m_pc = tgt;
      else begin m_redir = tgt; m_killing = 1; end
    end else if (ihit && !stall_PC) begin
      accepted = 1;
`ifdef FETCH_HALT_EN
      if (word == 32'hFFFF_FFFF) m_halted = 1;
`endif
    end
    if (flush_IFID) begin m_instr = 0; m_valid = 0; end
    else if (stall_IFID) begin end
    else if (accepted) begin m_instr = word; m_pc4 = m_pc + 32'd4; m_valid = 1; end
    else begin m_instr = 0; m_valid = 0; end
    if (accepted) m_pc = m_pc + 32'd4;
  endtask

  task automatic applyStimulus(input logic rst_n, input logic hit, input logic [31:0] load,
                               input logic [1:0] src, input logic spc, input logic sif,
                               input logic fl);
    nRST = rst_n; ihit = hit; iload = load; PCSrc = src;
    stall_PC = spc; stall_IFID = sif; flush_IFID = fl;
    #1;
    check32("iREN", {31'd0, iREN}, {31'd0, rst_n && m_known && !m_halted});
    if (m_known) check32("iaddr", iaddr, m_pc);
    model_edge();
    @(posedge CLK);
    #1;
    checkOutput();
  endtask

  task automatic checkOutput();
    check32("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
    check32("ifid_instr", ifid_instr, m_instr);
    if (m_valid) check32("ifid_pc4", ifid_pc4, m_pc4);
    check32("halt", {31'd0, halt}, {31'd0, m_halted});
    check32("iaddr_post", iaddr, m_pc);
  endtask

  initial begin
    m_known = 0; m_halted = 0; m_killing = 0; m_valid = 0;
    m_pc = 0; m_redir = 0; m_instr = 0; m_pc4 = 0;
    branch_tgt = 32'h40; jump_tgt = 32'h100; jr_tgt = 32'h200;

    // reset then streaming fetch with zero-wait memory
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    check32("reset_pc", iaddr, PC_INIT);
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 1, 32'h2001_0001 + i, 0, 0, 0, 0);
    check32("stream_pc", iaddr, 32'h10);
    check32("stream_pc4", ifid_pc4, 32'h10);

    // three wait cycles at PC 0x10
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 32'hDEAD_0000, 0, 0, 0, 0);
    applyStimulus(1, 1, 32'h2001_0010, 0, 0, 0, 0);
    check32("wait_pc4", ifid_pc4, 32'h14);

    // branch while request outstanding: stale word dropped
    applyStimulus(1, 0, 32'h0, 1, 0, 0, 0);
    applyStimulus(1, 0, 32'h0, 0, 0, 0, 0);
    applyStimulus(1, 1, 32'hBAD0_BAD0, 0, 0, 0, 0);
    check32("kill_dropped", {31'd0, ifid_valid}, 32'd0);
    check32("kill_target", iaddr, 32'h40);

    // last redirect in KILL wins
    applyStimulus(1, 0, 32'h0, 1, 0, 0, 0);
    applyStimulus(1, 0, 32'h0, 3, 0, 0, 0);
    applyStimulus(1, 1, 32'h0, 0, 0, 0, 0);
    check32("kill_last_wins", iaddr, 32'h200);

    // full stall, then flush beats stall
    applyStimulus(1, 1, 32'h1234_5678, 0, 0, 0, 0);
    applyStimulus(1, 1, 32'hAAAA_AAAA, 0, 1, 1, 0);
    applyStimulus(1, 1, 32'hBBBB_BBBB, 0, 1, 1, 0);
    check32("stall_instr", ifid_instr, 32'h1234_5678);
    applyStimulus(1, 1, 32'hCCCC_CCCC, 0, 1, 1, 1);
    applyStimulus(1, 1, 32'hDDDD_DDDD, 0, 1, 0, 0);

    // reset while in KILL
    applyStimulus(1, 0, 32'h0, 2, 0, 0, 0);
    applyStimulus(0, 1, 32'h5555_5555, 0, 0, 0, 0);
    check32("rst_kill_pc", iaddr, PC_INIT);
    applyStimulus(1, 1, 32'h6666_6666, 0, 0, 0, 0);
    check32("rst_kill_word", ifid_instr, 32'h6666_6666);

    // wraparound of PC+4
    branch_tgt = 32'hFFFF_FFFC;
    applyStimulus(1, 1, 32'h0, 1, 0, 0, 0);
    applyStimulus(1, 1, 32'h7777_7777, 0, 0, 0, 0);
    check32("wrap_pc", iaddr, 32'h0);

`ifdef FETCH_HALT_EN
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(1, 1, 32'h1000 + i, 0, 0, 0, 0);
    applyStimulus(1, 1, 32'hFFFF_FFFF, 0, 0, 0, 0);
    check32("halt_instr", ifid_instr, 32'hFFFF_FFFF);
    applyStimulus(1, 1, 32'h0, 0, 0, 0, 0);
    applyStimulus(1, 0, 32'h0, 2, 0, 0, 0);
    check32("unhalt_addr", iaddr, 32'h100);
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [1:0] src;
      logic [31:0] load;
      branch_tgt = $urandom; jump_tgt = $urandom; jr_tgt = $urandom;
      src  = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      load = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFF : $urandom;
      applyStimulus(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) < 7), load, src,
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 19) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
